// File: rtl/bank_req_scheduler.sv
// Bank-aware request scheduler: per-bank round-robin arbitration, registered
// bank commands and fixed-latency read return to the requesting slot.
module bank_req_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_BANKS   = 5,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 2,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SLOTS-1:0]            req_valid,
  output logic [NUM_SLOTS-1:0]            req_ready,
  input  logic [NUM_SLOTS-1:0]            req_we,
  input  logic [NUM_SLOTS*BW-1:0]         req_bank,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_SLOTS-1:0]            req_err,
  output logic [NUM_SLOTS-1:0]            rsp_valid,
  output logic [NUM_SLOTS*DATA_WIDTH-1:0] rsp_data,
  output logic [NUM_BANKS-1:0]            bank_en,
  output logic [NUM_BANKS-1:0]            bank_we,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata
);

  localparam int BWP = BW + 1;
  localparam logic [BW:0] BANK_LIMIT = BWP'(NUM_BANKS);

  logic [NUM_SLOTS-1:0]                       bad_s;
  logic [NUM_BANKS-1:0][NUM_SLOTS-1:0]        cand_s;
  logic [NUM_BANKS-1:0]                       win_valid_s;
  logic [NUM_BANKS-1:0][SW-1:0]               win_slot_s;
  logic [NUM_BANKS-1:0][SW-1:0]               ptr_r;
  logic [NUM_BANKS-1:0][RAM_LATENCY:0]        tag_valid_r;
  logic [NUM_BANKS-1:0][RAM_LATENCY:0][SW-1:0] tag_slot_r;

  // Sort valid requests into out-of-range slots and per-bank candidates.
  always_comb begin
    bad_s  = '0;
    cand_s = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!rst && req_valid[s]) begin
        if ({1'b0, req_bank[s*BW +: BW]} >= BANK_LIMIT) begin
          bad_s[s] = 1'b1;
        end else begin
          cand_s[int'(req_bank[s*BW +: BW])][s] = 1'b1;
        end
      end else begin
        bad_s[s] = 1'b0;
      end
    end
  end

  // Per bank: first candidate at or after the pointer, searching cyclically.
  always_comb begin
    win_valid_s = '0;
    win_slot_s  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (!win_valid_s[b] && cand_s[b][(int'(ptr_r[b]) + k) % NUM_SLOTS]) begin
          win_valid_s[b] = 1'b1;
          win_slot_s[b]  = SW'((int'(ptr_r[b]) + k) % NUM_SLOTS);
        end else begin
          win_valid_s[b] = win_valid_s[b];
        end
      end
    end
  end

  // Out-of-range requests are accepted at once; in-range ones when they win.
  always_comb begin
    req_ready = bad_s;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (win_valid_s[b] && (win_slot_s[b] == SW'(s))) begin
          req_ready[s] = 1'b1;
        end else begin
          req_ready[s] = req_ready[s];
        end
      end
    end
  end

  // Bank command registers, round-robin pointers and read-tag pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= '0;
      bank_en     <= '0;
      bank_we     <= '0;
      bank_addr   <= '0;
      bank_wdata  <= '0;
      tag_valid_r <= '0;
      tag_slot_r  <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_en[b]        <= win_valid_s[b];
        bank_we[b]        <= win_valid_s[b] & req_we[win_slot_s[b]];
        tag_valid_r[b][0] <= win_valid_s[b] & ~req_we[win_slot_s[b]];
        tag_slot_r[b][0]  <= win_slot_s[b];
        for (int i = 1; i <= RAM_LATENCY; i++) begin
          tag_valid_r[b][i] <= tag_valid_r[b][i-1];
          tag_slot_r[b][i]  <= tag_slot_r[b][i-1];
        end
        if (win_valid_s[b]) begin
          ptr_r[b] <= (win_slot_s[b] == SW'(NUM_SLOTS - 1)) ? SW'(0) : win_slot_s[b] + SW'(1);
          bank_addr[b*ADDR_WIDTH +: ADDR_WIDTH] <=
            req_addr[int'(win_slot_s[b])*ADDR_WIDTH +: ADDR_WIDTH];
          bank_wdata[b*DATA_WIDTH +: DATA_WIDTH] <=
            req_wdata[int'(win_slot_s[b])*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Route returning bank data to the tagged slot; flag accepted bad-bank requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      req_err   <= '0;
    end else begin
      req_err   <= bad_s;
      rsp_valid <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (tag_valid_r[b][RAM_LATENCY]) begin
          rsp_valid[tag_slot_r[b][RAM_LATENCY]] <= 1'b1;
          rsp_data[int'(tag_slot_r[b][RAM_LATENCY])*DATA_WIDTH +: DATA_WIDTH] <=
            bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_req_scheduler.sv
// Bench for bank_req_scheduler: directed scenarios and random traffic checked
// cycle by cycle against a reference model, with a latency-accurate RAM model.
module tb_bank_req_scheduler;

  localparam int NS    = 4;
  localparam int NB    = 5;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int RL    = 2;
  localparam int BW    = 3;
  localparam int DEPTH = 512;

  typedef struct packed {
    logic          we;
    logic [BW-1:0] bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b0;
  logic [NS-1:0]    req_valid, req_ready, req_we, req_err, rsp_valid;
  logic [NS*BW-1:0] req_bank;
  logic [NS*AW-1:0] req_addr;
  logic [NS*DW-1:0] req_wdata, rsp_data;
  logic [NB-1:0]    bank_en, bank_we;
  logic [NB*AW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_wdata, bank_rdata;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rand_mode = 1'b0;

  req_t q [NS][$];
  req_t pend [NS];
  bit   pend_v [NS];
  int   ptr [NB];
  logic [DW-1:0] shadow [NB][DEPTH];
  logic [DW-1:0] last_rd [NS];
  logic [NB-1:0] e_en [8];
  logic [NB-1:0] e_we [8];
  logic [AW-1:0] e_addr [8][NB];
  logic [DW-1:0] e_wdata [8][NB];
  logic [NS-1:0] e_rv [8];
  logic [NS-1:0] e_err [8];
  logic [DW-1:0] e_rd [8][NS];
  int glog [$];
  int err_obs [NS];
  int rsp_obs [NS];
  logic [DW-1:0] rsp1_data [$];
  int rsp1_cyc [$];

  logic [DW-1:0] ram [NB][DEPTH];
  logic [DW-1:0] rpipe [NB][RL];

  always #5 clk = ~clk;

  bank_req_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_err(req_err), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int b, input int a);
    if (b == 2 && a == 32'h15) return 32'hDEAD_BEEF;
    else return 32'h5A00_0000 ^ (32'(b) << 16) ^ 32'(a);
  endfunction

  function automatic req_t mk(input logic we, input int bank, input int addr, input logic [DW-1:0] data);
    req_t r;
    r.we = we; r.bank = BW'(bank); r.addr = AW'(addr); r.data = data;
    return r;
  endfunction

  // RAM banks: data for an access strobed in cycle C is on bank_rdata in cycle C+RL.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_init) begin
        for (int a = 0; a < DEPTH; a++) ram[b][a] <= init_val(b, a);
      end else if (bank_en[b]) begin
        if (bank_we[b]) ram[b][bank_addr[b*AW +: AW]] <= bank_wdata[b*DW +: DW];
        rpipe[b][0] <= ram[b][bank_addr[b*AW +: AW]];
      end
      for (int i = 1; i < RL; i++) rpipe[b][i] <= rpipe[b][i-1];
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = rpipe[b][RL-1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      e_en[k] = '0; e_we[k] = '0; e_rv[k] = '0; e_err[k] = '0;
    end
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    for (int s = 0; s < NS; s++) last_rd[s] = '0;
  endtask

  task automatic refill_and_drive();
    req_t r;
    for (int s = 0; s < NS; s++) begin
      if (!pend_v[s]) begin
        if (q[s].size() > 0) begin
          pend[s] = q[s].pop_front();
          pend_v[s] = 1'b1;
        end else if (rand_mode && $urandom_range(0, 3) != 32'd0) begin
          r.we   = 1'($urandom_range(0, 1));
          r.bank = ($urandom_range(0, 15) < 32'd14) ? BW'($urandom_range(0, NB - 1))
                                                    : BW'($urandom_range(NB, 7));
          r.addr = AW'($urandom_range(0, 15));
          r.data = $urandom();
          pend[s] = r;
          pend_v[s] = 1'b1;
        end
      end
      req_valid[s]           = pend_v[s];
      req_we[s]              = pend_v[s] & pend[s].we;
      req_bank[s*BW +: BW]   = pend[s].bank;
      req_addr[s*AW +: AW]   = pend[s].addr;
      req_wdata[s*DW +: DW]  = pend[s].data;
    end
  endtask

  // One clock: check outputs on the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [NS-1:0] exp_rdy;
    int win [NB];
    int k, kn, kr, bk;
    exp_rdy = '0;
    @(negedge clk);
    for (int b = 0; b < NB; b++) win[b] = -1;
    for (int s = 0; s < NS; s++) begin
      if (!rst && pend_v[s]) begin
        bk = int'(pend[s].bank);
        if (bk >= NB) exp_rdy[s] = 1'b1;
        else if (win[bk] < 0 || (s - ptr[bk] + NS) % NS < (win[bk] - ptr[bk] + NS) % NS) win[bk] = s;
      end
    end
    for (int b = 0; b < NB; b++) if (win[b] >= 0) exp_rdy[win[b]] = 1'b1;
    for (int s = 0; s < NS; s++) begin
      if (req_valid[s] && req_ready[s] && req_bank[s*BW +: BW] == 3'd1) glog.push_back(s);
      err_obs[s] += int'(req_err[s]);
      rsp_obs[s] += int'(rsp_valid[s]);
    end
    if (rsp_valid[1]) begin
      rsp1_data.push_back(rsp_data[DW +: DW]);
      rsp1_cyc.push_back(cyc);
    end
    k = cyc % 8;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("bank_en", 64'(bank_en), 64'(e_en[k]));
    chk("bank_we", 64'(bank_we), 64'(e_we[k]));
    for (int b = 0; b < NB; b++) begin
      if (e_en[k][b]) begin
        chk("bank_addr", 64'(bank_addr[b*AW +: AW]), 64'(e_addr[k][b]));
        if (e_we[k][b]) chk("bank_wdata", 64'(bank_wdata[b*DW +: DW]), 64'(e_wdata[k][b]));
      end
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv[k]));
    chk("req_err", 64'(req_err), 64'(e_err[k]));
    for (int s = 0; s < NS; s++) begin
      if (e_rv[k][s]) last_rd[s] = e_rd[k][s];
      chk("rsp_data", 64'(rsp_data[s*DW +: DW]), 64'(last_rd[s]));
    end
    e_en[k] = '0; e_we[k] = '0; e_rv[k] = '0; e_err[k] = '0;
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      kn = (cyc + 1) % 8;
      kr = (cyc + 2 + RL) % 8;
      for (int s = 0; s < NS; s++) begin
        if (exp_rdy[s]) begin
          bk = int'(pend[s].bank);
          if (bk >= NB) begin
            e_err[kn][s] = 1'b1;
          end else begin
            e_en[kn][bk]    = 1'b1;
            e_we[kn][bk]    = pend[s].we;
            e_addr[kn][bk]  = pend[s].addr;
            e_wdata[kn][bk] = pend[s].data;
            if (pend[s].we) begin
              shadow[bk][pend[s].addr] = pend[s].data;
            end else begin
              e_rv[kr][s] = 1'b1;
              e_rd[kr][s] = shadow[bk][pend[s].addr];
            end
            ptr[bk] = (s + 1) % NS;
          end
          pend_v[s] = 1'b0;
        end
      end
    end
    cyc++;
    #1;
    refill_and_drive();
  endtask

  task automatic drain(input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      busy = 1'b0;
      for (int s = 0; s < NS; s++) if (pend_v[s] || q[s].size() > 0) busy = 1'b1;
      if (busy) begin
        step();
        n++;
      end
    end
    chk("drain_done", 64'(busy), 64'(0));
    repeat (RL + 3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int e0, r0;
    req_valid = '0; req_we = '0; req_bank = '0; req_addr = '0; req_wdata = '0;
    clear_model();
    for (int s = 0; s < NS; s++) begin
      pend_v[s] = 1'b0; err_obs[s] = 0; rsp_obs[s] = 0;
    end
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) shadow[b][a] = init_val(b, a);

    // Reset state, with requests presented while reset is held
    rst = 1'b1;
    ram_init = 1'b1;
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_bank_en", 64'(bank_en), 64'(0));
    chk("rst_bank_we", 64'(bank_we), 64'(0));
    chk("rst_bank_addr", 64'(bank_addr), 64'(0));
    chk("rst_bank_wdata", 64'(bank_wdata != '0), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data != '0), 64'(0));
    chk("rst_req_err", 64'(req_err), 64'(0));
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;

    // Single read of a preloaded word
    q[0].push_back(mk(1'b0, 2, 32'h15, 32'h0));
    drain(50);
    chk("t1_rdata", 64'(rsp_data[0 +: DW]), 64'(32'hDEAD_BEEF));

    // All slots contending for bank 1 straight out of reset
    do_reset();
    glog.delete();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 8; i++) q[s].push_back(mk(1'b0, 1, s * 8 + i, 32'h0));
    drain(100);
    chk("t2_count", 64'(glog.size()), 64'(32));
    for (int i = 0; i < glog.size(); i++) chk("t2_order", 64'(glog[i]), 64'(i % NS));

    // Parallel write then read-back, one bank per slot
    for (int s = 0; s < NS; s++) begin
      q[s].push_back(mk(1'b1, s, 32'h20, 32'h100 + 32'(s)));
      q[s].push_back(mk(1'b0, s, 32'h20, 32'h0));
    end
    drain(50);
    for (int s = 0; s < NS; s++) chk("t3_rdata", 64'(rsp_data[s*DW +: DW]), 64'(32'h100 + 32'(s)));

    // Out-of-range bank read
    e0 = err_obs[2];
    r0 = rsp_obs[2];
    q[2].push_back(mk(1'b0, 7, 3, 32'h0));
    drain(50);
    chk("t4_err_pulses", 64'(err_obs[2] - e0), 64'(1));
    chk("t4_no_rsp", 64'(rsp_obs[2] - r0), 64'(0));

    // Back-to-back reads from one slot
    rsp1_data.delete();
    rsp1_cyc.delete();
    for (int a = 0; a < 8; a++) q[1].push_back(mk(1'b0, 3, a, 32'h0));
    drain(50);
    chk("t5_count", 64'(rsp1_data.size()), 64'(8));
    for (int a = 0; a < rsp1_data.size(); a++) chk("t5_data", 64'(rsp1_data[a]), 64'(init_val(3, a)));
    if (rsp1_cyc.size() == 8) chk("t5_span", 64'(rsp1_cyc[7] - rsp1_cyc[0]), 64'(7));
    else chk("t5_span", 64'(rsp1_cyc.size()), 64'(8));

    // Random mixed traffic
    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    drain(200);

    // Reset two cycles after a read handshake drops the read and the pointers
    r0 = rsp_obs[0];
    q[0].push_back(mk(1'b0, 0, 5, 32'h0));
    step();
    step();
    step();
    do_reset();
    repeat (6) step();
    chk("t6_dropped", 64'(rsp_obs[0] - r0), 64'(0));
    glog.delete();
    for (int s = NS - 1; s >= 0; s--) q[s].push_back(mk(1'b0, 1, s, 32'h0));
    drain(50);
    chk("t6_first_winner", 64'(glog.size() > 0 ? glog[0] : -1), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
